// File: rtl/apb_master_fsm.sv
// apb_master_fsm: single-request APB master with two-slave address decode and a wait-state timeout
module apb_master_fsm #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 8,
  parameter int SELBIT    = 7,
  parameter int TIMEOUT   = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 transfer,
  input  logic                 wr,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0] wdata,
  output logic                 ready,
  output logic                 done,
  output logic                 err,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 PSEL1,
  output logic                 PSEL2,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0] PWDATA,
  input  logic                 PREADY,
  input  logic [DATAWIDTH-1:0] PRDATA
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] waitcnt_q, waitcnt_d;
  logic timeout_hit, fin, accept;
  assign timeout_hit = state_q == ACCESS && waitcnt_q == CW'(TIMEOUT - 1) && !PREADY;
  assign fin = state_q == ACCESS && (PREADY || timeout_hit);
  assign ready = !PRESET && (state_q == IDLE || fin);
  assign accept = transfer && ready;
  always_comb begin
    state_d = accept ? SETUP : state_q == SETUP ? ACCESS : fin ? IDLE : state_q;
    waitcnt_d = state_q == SETUP ? '0 : (state_q == ACCESS && !fin) ? waitcnt_q + 1'b1 : waitcnt_q;
  end
  // a back-to-back accept on the exit edge wins over deselecting the finished slave
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      waitcnt_q <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      state_q   <= state_d;
      waitcnt_q <= waitcnt_d;
      done      <= fin;
      err       <= timeout_hit;
      rdata     <= timeout_hit ? '0 : (fin && !PWRITE) ? PRDATA : rdata;
      PSEL1     <= accept ? !addr[SELBIT] : fin ? 1'b0 : PSEL1;
      PSEL2     <= accept ? addr[SELBIT] : fin ? 1'b0 : PSEL2;
      PENABLE   <= state_d == ACCESS;
      PWRITE    <= accept ? wr : PWRITE;
      PADDR     <= accept ? addr : PADDR;
      PWDATA    <= (accept && wr) ? wdata : PWDATA;
    end
  end
endmodule

// File: tb/tb_apb_master_fsm.sv
// tb_apb_master_fsm: directed vector table plus hand-written multi-cycle sequences for apb_master_fsm
module tb_apb_master_fsm;
  logic PCLK = 1'b0, PRESET = 1'b1, transfer = 1'b0, wr = 1'b0, PREADY = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [31:0] wdata = 32'h0, PRDATA = 32'h0;
  logic ready, done, err, PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR;
  logic [31:0] PWDATA, rdata;
  int total = 0, bad = 0;
  apb_master_fsm dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .wr(wr), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .err(err), .rdata(rdata), .PSEL1(PSEL1), .PSEL2(PSEL2),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA)
  );
  always #5 PCLK = ~PCLK;
  typedef struct {
    logic tr, w; logic [7:0] a; logic [31:0] wd; logic prdy; logic [31:0] prd;
    logic rdy, s1, s2, en, pw, dn, er; logic [7:0] pa; logic [31:0] pwd, rd;
  } vec_t;
  vec_t v[10];
  task automatic chk(input string nm, input logic [78:0] act, input logic [78:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [78:0] outs();
    return {ready, PSEL1, PSEL2, PENABLE, PWRITE, done, err, PADDR, PWDATA, rdata};
  endfunction
  initial begin
    int dc, cnt, s1cnt;
    logic ok;
    // rows: inputs driven for the cycle, then the outputs expected during that cycle
    v[0] = '{1'b1, 1'b1, 8'h12, 32'hDEADBEEF, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0};
    v[1] = '{1'b0, 1'b1, 8'h12, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 32'hDEADBEEF, 32'h0};
    v[2] = '{1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 32'hDEADBEEF, 32'h0};
    v[3] = '{1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h12, 32'hDEADBEEF, 32'h0};
    v[4] = '{1'b1, 1'b1, 8'h01, 32'h11112222, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 32'hDEADBEEF, 32'h0};
    v[5] = '{1'b1, 1'b0, 8'h81, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 32'h11112222, 32'h0};
    v[6] = '{1'b1, 1'b0, 8'h81, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 32'h11112222, 32'h0};
    v[7] = '{1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h81, 32'h11112222, 32'h0};
    v[8] = '{1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 32'h0BADF00D, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 32'h11112222, 32'h0};
    v[9] = '{1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h81, 32'h11112222, 32'h0BADF00D};
    @(negedge PCLK);
    @(negedge PCLK);
    chk("reset_state", outs(), 79'd0);
    PRESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      transfer = v[i].tr; wr = v[i].w; addr = v[i].a; wdata = v[i].wd; PREADY = v[i].prdy; PRDATA = v[i].prd;
      #1;
      chk($sformatf("row%0d", i), outs(),
          {v[i].rdy, v[i].s1, v[i].s2, v[i].en, v[i].pw, v[i].dn, v[i].er, v[i].pa, v[i].pwd, v[i].rd});
    end
    // read from slave2 with three wait states
    @(negedge PCLK);
    transfer = 1'b1; wr = 1'b0; addr = 8'h85; PREADY = 1'b0;
    #1 chk("wait_accept_ready", 79'(ready), 79'd1);
    dc = 0; cnt = 0; s1cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge PCLK);
      transfer = 1'b0; PREADY = (c == 5); PRDATA = (c == 5) ? 32'hCAFE0001 : 32'hFFFFFFFF;
      #1;
      if (c == 1) chk("wait_setup_penable", 79'(PENABLE), 79'd0);
      cnt += int'(PSEL2); s1cnt += int'(PSEL1);
      if (done) begin dc = c; break; end
    end
    chk("wait_done_latency", 79'(dc), 79'd6);
    chk("wait_psel2_cycles", 79'(cnt), 79'd5);
    chk("wait_psel1_never", 79'(s1cnt), 79'd0);
    chk("wait_rdata_err", {err, rdata}, {1'b0, 32'hCAFE0001});
    // timeout on a read that never gets PREADY
    @(negedge PCLK);
    transfer = 1'b1; wr = 1'b0; addr = 8'h10; PREADY = 1'b0; PRDATA = 32'h77777777;
    dc = 0; cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge PCLK);
      transfer = 1'b0;
      #1;
      cnt += int'(PENABLE);
      if (done) begin dc = c; break; end
    end
    chk("to_done_latency", 79'(dc), 79'd18);
    chk("to_penable_cycles", 79'(cnt), 79'd16);
    chk("to_err_rdata_sel", {err, PSEL1, PSEL2, PENABLE, rdata}, {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    @(negedge PCLK);
    #1 chk("to_pulse_single", {77'd0, done, err}, 79'd0);
    // request pulsed during SETUP is ignored
    transfer = 1'b1; wr = 1'b1; addr = 8'h22; wdata = 32'h5A5A5A5A; PREADY = 1'b1;
    cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge PCLK);
      transfer = (c == 1); wr = 1'b0; addr = (c == 1) ? 8'h55 : 8'h00; wdata = 32'h0;
      #1;
      if (c == 1) chk("ign_setup_ready", 79'(ready), 79'd0);
      if (c == 2) chk("ign_paddr_held", {39'd0, PWRITE, PADDR, PWDATA}, {39'd0, 1'b1, 8'h22, 32'h5A5A5A5A});
      cnt += int'(done);
    end
    chk("ign_done_count", 79'(cnt), 79'd1);
    // reset in the second wait cycle of an ACCESS
    @(negedge PCLK);
    transfer = 1'b1; wr = 1'b1; addr = 8'h90; wdata = 32'h12345678; PREADY = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge PCLK);
      transfer = 1'b0;
    end
    #1 chk("rst_pre_access", {PSEL2, PENABLE, PADDR}, {1'b1, 1'b1, 8'h90});
    PRESET = 1'b1;
    #1 chk("rst_async_clear", {ready, PSEL1, PSEL2, PENABLE, PADDR, PWDATA}, 44'd0);
    ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge PCLK);
      #1 ok = ok & !done & !err;
    end
    chk("rst_no_done", 79'(ok), 79'd1);
    PRESET = 1'b0;
    @(negedge PCLK);
    transfer = 1'b1; wr = 1'b1; addr = 8'h07; wdata = 32'hA5A5A5A5; PREADY = 1'b1;
    dc = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge PCLK);
      transfer = 1'b0;
      #1;
      if (done) begin dc = c; break; end
    end
    chk("post_rst_latency", 79'(dc), 79'd3);
    chk("post_rst_result", {err, PWRITE, PADDR, PWDATA}, {1'b0, 1'b1, 8'h07, 32'hA5A5A5A5});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
